// File: rtl/pc_ifid_ctrl_if.sv
// ---------------------------------------------------------------------------
// pc_ifid_ctrl_if
// Groups the signals exchanged between the front-end sequencer and the rest of
// the pipeline (instruction memory, decode, hazard unit).
//   Pipeline -> sequencer: instr_in, JMP, pc_sign, jump_target, branch_target,
//                          Hazard_signal, speccial_hazard, flush, IRQ, bad_signal
//   Sequencer -> pipeline: PC, PC31, IF_ID_Instr, IF_ID_PC4, ID_valid, HZ_rec, EPC
// Modports:
//   master - the surrounding pipeline (drives controls, observes state)
//   slave  - the sequencer itself
// ---------------------------------------------------------------------------
interface pc_ifid_ctrl_if;
    logic [31:0] instr_in;
    logic [2:0]  JMP;
    logic        pc_sign;
    logic [31:0] jump_target;
    logic [31:0] branch_target;
    logic        Hazard_signal;
    logic        speccial_hazard;
    logic        flush;
    logic        IRQ;
    logic        bad_signal;

    logic [31:0] PC;
    logic        PC31;
    logic [31:0] IF_ID_Instr;
    logic [31:0] IF_ID_PC4;
    logic        ID_valid;
    logic        HZ_rec;
    logic [31:0] EPC;

    modport master (
        output instr_in, JMP, pc_sign, jump_target, branch_target,
               Hazard_signal, speccial_hazard, flush, IRQ, bad_signal,
        input  PC, PC31, IF_ID_Instr, IF_ID_PC4, ID_valid, HZ_rec, EPC
    );

    modport slave (
        input  instr_in, JMP, pc_sign, jump_target, branch_target,
               Hazard_signal, speccial_hazard, flush, IRQ, bad_signal,
        output PC, PC31, IF_ID_Instr, IF_ID_PC4, ID_valid, HZ_rec, EPC
    );
endinterface

// File: rtl/pc_ifid_ctrl.sv
// ---------------------------------------------------------------------------
// pc_ifid_ctrl
// Front-end sequencer of the five-stage pipeline. Owns the PC register, the
// IF/ID pipeline register, the exception PC and the HZ_rec handshake flop.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high; loads RESET_VEC and clears IF/ID
//   bus   - pc_ifid_ctrl_if.slave (controls in, PC / IF/ID / EPC out)
// Next-PC priority: reset, undefined instruction, interrupt (user mode only),
// stall, jump, taken branch, sequential.
// ---------------------------------------------------------------------------
module pc_ifid_ctrl #(
    parameter logic [31:0] RESET_VEC = 32'h8000_0000,
    parameter logic [31:0] IRQ_VEC   = 32'h8000_0004,
    parameter logic [31:0] EXC_VEC   = 32'h8000_0008
) (
    input  logic          clk,
    input  logic          reset,
    pc_ifid_ctrl_if.slave bus
);

    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] id_pc4_q;
    logic        id_valid_q;
    logic        hz_rec_q;
    logic [31:0] epc_q;

    logic [31:0] pc4;
    logic        stall;
    logic        irq_take;
    logic        trap_entry;
    logic [31:0] pc_next;

    // NOTE: every signal written here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        // Bit 31 (kernel flag) is never carried into by sequential fetch.
        pc4        = {pc_q[31], pc_q[30:0] + 31'd4};
        stall      = bus.Hazard_signal | bus.speccial_hazard;
        // Interrupts are masked in kernel space; IRQ is a level and waits.
        irq_take   = bus.IRQ & ~pc_q[31];
        trap_entry = bus.bad_signal | irq_take;

        pc_next = pc4;
        if (bus.bad_signal) begin
            pc_next = EXC_VEC;
        end else if (irq_take) begin
            pc_next = IRQ_VEC;
        end else if (stall) begin
            pc_next = pc_q;
        end else if (bus.JMP == 3'b010) begin
            pc_next = bus.jump_target;
        end else if (bus.JMP == 3'b001 && bus.pc_sign) begin
            pc_next = bus.branch_target;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_VEC;
            instr_q    <= '0;
            id_pc4_q   <= '0;
            id_valid_q <= 1'b0;
            hz_rec_q   <= 1'b0;
            epc_q      <= '0;
        end else begin
            pc_q <= pc_next;

            if (trap_entry) begin
                // The instruction in ID is squashed and re-executed on return.
                instr_q    <= '0;
                id_valid_q <= 1'b0;
                epc_q      <= id_pc4_q - 32'd4;
                hz_rec_q   <= 1'b0;
            end else begin
                // Stall holds IF/ID and overrides a simultaneous flush.
                if (!stall) begin
                    if (bus.flush) begin
                        instr_q    <= '0;
                        id_valid_q <= 1'b0;
                    end else begin
                        instr_q    <= bus.instr_in;
                        id_pc4_q   <= pc4;
                        id_valid_q <= 1'b1;
                    end
                end

                // Records that the branch-in-ID stall was taken; stays set
                // through an overlapping load-use stall so the hazard unit
                // does not request the special stall a second time.
                if (bus.speccial_hazard) begin
                    hz_rec_q <= 1'b1;
                end else if (!bus.Hazard_signal) begin
                    hz_rec_q <= 1'b0;
                end
            end
        end
    end

    assign bus.PC          = pc_q;
    assign bus.PC31        = pc_q[31];
    assign bus.IF_ID_Instr = instr_q;
    assign bus.IF_ID_PC4   = id_pc4_q;
    assign bus.ID_valid    = id_valid_q;
    assign bus.HZ_rec      = hz_rec_q;
    assign bus.EPC         = epc_q;

endmodule

// File: tb/tb_pc_ifid_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pc_ifid_ctrl
// Self-checking bench for pc_ifid_ctrl: a directed vector table with
// hand-derived expectations, a short pending-interrupt sequence, and a
// randomized run compared against a behavioural model.
// ---------------------------------------------------------------------------
module tb_pc_ifid_ctrl;

    localparam logic [31:0] RESET_VEC = 32'h8000_0000;
    localparam logic [31:0] IRQ_VEC   = 32'h8000_0004;
    localparam logic [31:0] EXC_VEC   = 32'h8000_0008;

    typedef struct packed {
        logic        rst;
        logic [2:0]  jmp;
        logic        sign;
        logic [31:0] jt;
        logic [31:0] bt;
        logic        hz;
        logic        sp;
        logic        fl;
        logic        irq;
        logic        bad;
        logic [31:0] instr;
    } in_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        hzrec;
        logic [31:0] epc;
    } st_t;

    typedef struct packed {
        in_t in;
        st_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    pc_ifid_ctrl_if bus ();

    pc_ifid_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input st_t e);
        check({tag, " PC"},          bus.PC,                e.pc);
        check({tag, " PC31"},        {31'd0, bus.PC31},     {31'd0, e.pc[31]});
        check({tag, " IF_ID_Instr"}, bus.IF_ID_Instr,       e.instr);
        check({tag, " IF_ID_PC4"},   bus.IF_ID_PC4,         e.pc4);
        check({tag, " ID_valid"},    {31'd0, bus.ID_valid}, {31'd0, e.valid});
        check({tag, " HZ_rec"},      {31'd0, bus.HZ_rec},   {31'd0, e.hzrec});
        check({tag, " EPC"},         bus.EPC,               e.epc);
    endtask

    task automatic drive(input in_t i);
        reset               = i.rst;
        bus.JMP             = i.jmp;
        bus.pc_sign         = i.sign;
        bus.jump_target     = i.jt;
        bus.branch_target   = i.bt;
        bus.Hazard_signal   = i.hz;
        bus.speccial_hazard = i.sp;
        bus.flush           = i.fl;
        bus.IRQ             = i.irq;
        bus.bad_signal      = i.bad;
        bus.instr_in        = i.instr;
    endtask

    // Apply inputs, take one rising edge, settle away from the edge.
    task automatic step(input in_t i);
        drive(i);
        @(posedge clk);
        #1;
    endtask

    function automatic in_t mk_in(input logic rst, input logic [2:0] jmp, input logic sign,
                                  input logic [31:0] jt, input logic [31:0] bt,
                                  input logic hz, input logic sp, input logic fl,
                                  input logic irq, input logic bad, input logic [31:0] instr);
        in_t i;
        i.rst = rst; i.jmp = jmp; i.sign = sign; i.jt = jt; i.bt = bt;
        i.hz = hz; i.sp = sp; i.fl = fl; i.irq = irq; i.bad = bad; i.instr = instr;
        return i;
    endfunction

    function automatic st_t mk_st(input logic [31:0] pc, input logic [31:0] instr,
                                  input logic [31:0] pc4, input logic valid,
                                  input logic hzrec, input logic [31:0] epc);
        st_t s;
        s.pc = pc; s.instr = instr; s.pc4 = pc4; s.valid = valid; s.hzrec = hzrec; s.epc = epc;
        return s;
    endfunction

    // Behavioural reference: the architectural effect of one clock edge.
    function automatic st_t model_step(input st_t s, input in_t i);
        st_t         n;
        logic [31:0] seq_pc;
        logic        kernel;
        n      = s;
        kernel = s.pc[31];
        seq_pc = kernel ? (32'h8000_0000 | ((s.pc + 32'd4) & 32'h7FFF_FFFF))
                        : ((s.pc + 32'd4) & 32'h7FFF_FFFF);
        if (i.rst) begin
            n = mk_st(RESET_VEC, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        end else if (i.bad || (i.irq && !kernel)) begin
            n.pc    = i.bad ? EXC_VEC : IRQ_VEC;
            n.instr = 32'd0;
            n.valid = 1'b0;
            n.epc   = s.pc4 - 32'd4;
            n.hzrec = 1'b0;
        end else begin
            if (!(i.hz || i.sp)) begin
                case (1'b1)
                    (i.jmp == 3'b010):          n.pc = i.jt;
                    (i.jmp == 3'b001 && i.sign): n.pc = i.bt;
                    default:                    n.pc = seq_pc;
                endcase
                if (i.fl) begin
                    n.instr = 32'd0;
                    n.valid = 1'b0;
                end else begin
                    n.instr = i.instr;
                    n.pc4   = seq_pc;
                    n.valid = 1'b1;
                end
            end
            if (i.sp)      n.hzrec = 1'b1;
            else if (i.hz) n.hzrec = s.hzrec;
            else           n.hzrec = 1'b0;
        end
        return n;
    endfunction

    vec_t vecs[$];

    function automatic void add(input in_t i, input st_t e);
        vec_t v;
        v.in  = i;
        v.exp = e;
        vecs.push_back(v);
    endfunction

    initial begin
        st_t  m;
        in_t  r;
        drive(mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        //      rst jmp sg jt            bt            hz sp fl irq bad instr
        // Reset held two cycles, then sequential fetch from RESET_VEC.
        add(mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hA000_0000), mk_st(32'h8000_0000, 0, 0, 0, 0, 0));
        add(mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hA000_0001), mk_st(32'h8000_0000, 0, 0, 0, 0, 0));
        add(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hA000_0002), mk_st(32'h8000_0004, 32'hA000_0002, 32'h8000_0004, 1, 0, 0));
        add(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hA000_0003), mk_st(32'h8000_0008, 32'hA000_0003, 32'h8000_0008, 1, 0, 0));
        add(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hA000_0004), mk_st(32'h8000_000C, 32'hA000_0004, 32'h8000_000C, 1, 0, 0));
        add(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hA000_0005), mk_st(32'h8000_0010, 32'hA000_0005, 32'h8000_0010, 1, 0, 0));
        // Load-use stall at 0x80000010: everything held, HZ_rec stays 0.
        add(mk_in(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'hA000_0006), mk_st(32'h8000_0010, 32'hA000_0005, 32'h8000_0010, 1, 0, 0));
        add(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hA000_0007), mk_st(32'h8000_0014, 32'hA000_0007, 32'h8000_0014, 1, 0, 0));
        // Jump under stall is held, then taken.
        add(mk_in(0, 2, 0, 32'h0040_0000, 0, 1, 0, 0, 0, 0, 32'hA000_0008), mk_st(32'h8000_0014, 32'hA000_0007, 32'h8000_0014, 1, 0, 0));
        add(mk_in(0, 2, 0, 32'h0040_0000, 0, 0, 0, 0, 0, 0, 32'hA000_0009), mk_st(32'h0040_0000, 32'hA000_0009, 32'h8000_0018, 1, 0, 0));
        add(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hA000_000A), mk_st(32'h0040_0004, 32'hA000_000A, 32'h0040_0004, 1, 0, 0));
        // Branch handshake: special stall, then resolve with redirect + flush.
        add(mk_in(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'hA000_000B), mk_st(32'h0040_0004, 32'hA000_000A, 32'h0040_0004, 1, 1, 0));
        add(mk_in(0, 1, 1, 0, 32'h0040_0100, 0, 0, 1, 0, 0, 32'hA000_000C), mk_st(32'h0040_0100, 0, 32'h0040_0004, 0, 0, 0));
        add(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hA000_000D), mk_st(32'h0040_0104, 32'hA000_000D, 32'h0040_0104, 1, 0, 0));
        // Reach PC=0x00400020 with IF_ID_PC4=0x0040001C, then interrupt.
        add(mk_in(0, 2, 0, 32'h0040_0018, 0, 0, 0, 0, 0, 0, 32'hA000_000E), mk_st(32'h0040_0018, 32'hA000_000E, 32'h0040_0108, 1, 0, 0));
        add(mk_in(0, 2, 0, 32'h0040_0020, 0, 0, 0, 0, 0, 0, 32'hA000_000F), mk_st(32'h0040_0020, 32'hA000_000F, 32'h0040_001C, 1, 0, 0));
        add(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hA000_0010), mk_st(32'h8000_0004, 0, 32'h0040_001C, 0, 0, 32'h0040_0018));
        // IRQ still high in kernel space: no re-entry.
        add(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hA000_0011), mk_st(32'h8000_0008, 32'hA000_0011, 32'h8000_0008, 1, 0, 32'h0040_0018));
        add(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hA000_0012), mk_st(32'h8000_000C, 32'hA000_0012, 32'h8000_000C, 1, 0, 32'h0040_0018));
        // bad_signal + IRQ + special hazard: exception vector, HZ_rec cleared.
        add(mk_in(0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 32'hA000_0013), mk_st(32'h8000_0008, 0, 32'h8000_000C, 0, 0, 32'h8000_0008));
        // Reset mid-stall and mid-redirect.
        add(mk_in(1, 2, 0, 32'h0040_0000, 0, 1, 0, 0, 0, 0, 32'hA000_0014), mk_st(32'h8000_0000, 0, 0, 0, 0, 0));
        // Special hazard overlapped by load-use: HZ_rec held until it clears.
        add(mk_in(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'hA000_0015), mk_st(32'h8000_0000, 0, 0, 0, 1, 0));
        add(mk_in(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'hA000_0016), mk_st(32'h8000_0000, 0, 0, 0, 1, 0));
        add(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hA000_0017), mk_st(32'h8000_0004, 32'hA000_0017, 32'h8000_0004, 1, 0, 0));
        // Flush during a stall is ignored.
        add(mk_in(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 32'hA000_0018), mk_st(32'h8000_0004, 32'hA000_0017, 32'h8000_0004, 1, 0, 0));

        @(negedge clk);
        foreach (vecs[k]) begin
            step(vecs[k].in);
            check_state($sformatf("vec%0d", k), vecs[k].exp);
        end

        // Pending IRQ is serviced once the PC leaves kernel space.
        step(mk_in(0, 2, 0, 32'h0040_0000, 0, 0, 0, 0, 1, 0, 32'hB000_0000));
        check_state("irq_pend_jump", mk_st(32'h0040_0000, 32'hB000_0000, 32'h8000_0008, 1, 0, 0));
        step(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hB000_0001));
        check_state("irq_pend_take", mk_st(IRQ_VEC, 0, 32'h8000_0008, 0, 0, 32'h8000_0004));

        // Randomized run against the behavioural model; starts from reset.
        m = mk_st(32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        for (int n = 0; n < 400; n++) begin
            r.rst   = (n == 0) || ($urandom_range(0, 39) == 0);
            r.jmp   = 3'($urandom_range(0, 7));
            r.sign  = 1'($urandom_range(0, 1));
            r.jt    = $urandom & 32'hFFFF_FFFC;
            r.bt    = $urandom & 32'hFFFF_FFFC;
            r.hz    = ($urandom_range(0, 4) == 0);
            r.sp    = ($urandom_range(0, 5) == 0);
            r.fl    = ($urandom_range(0, 3) == 0);
            r.irq   = ($urandom_range(0, 5) == 0);
            r.bad   = ($urandom_range(0, 19) == 0);
            r.instr = $urandom;
            m = model_step(m, r);
            step(r);
            check_state($sformatf("rand%0d", n), m);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
